dds_func_gen: RTL
=================

Name: dds_func_gen

Overview:
- Parametrised DDS digital function generator: phase accumulator driving sine, square, sawtooth, triangle, noise and DC waveforms.
- Unsigned offset-binary output feeds the external DAC.
- Successor to the fixed 8-bit count/recurrence generator, adding:
  - programmable frequency (tuning word) and square-wave duty;
  - glitch-free config updates, applied only at period boundaries through a valid/ready handshake;
  - period sync pulse and phase clear.

Parameters:
- OUT_W, 8, output sample width; legal range 4..16.
- PHASE_W, 16, phase accumulator and tuning-word width; must be ≥ OUT_W+1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  advance enable; when low, all state holds.
- phase_clr  in  1  synchronous phase clear.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  config accept; equals ~pending.
- cfg_mode  in  3  waveform select.
- cfg_ftw  in  PHASE_W  frequency tuning word.
- cfg_duty  in  OUT_W  square duty threshold / DC level.
- out  out  OUT_W  waveform sample, offset binary.
- wrap  out  1  one-cycle pulse on the first sample of each period.

Behaviour:
- Notation: N = 2^(OUT_W-1); MAX = 2^OUT_W-1.
- Reset values:
  - acc=0, carry_r=0, lfsr=16'hACE1, pending=0;
  - active mode=0, ftw=0, duty=N;
  - out=N, wrap=0, cfg_ready=1.
- Config handshake:
  - Transfer occurs on a clk edge with cfg_valid & cfg_ready; the cfg_* fields go to a shadow register and pending is set to 1.
  - While pending=1, cfg_ready=0 and further requests are stalled.
- Config apply (active <= shadow, pending <= 0) happens on an edge where pending=1 and any of the following holds:
  - en=0;
  - phase_clr=1;
  - the accumulator update on that edge carries out.
- A transfer and an apply cannot coincide; the earliest apply is the edge after the transfer.
- Stage 1, on each edge with en=1:
  - {carry_r, acc} <= acc + active ftw (ftw before any apply on the same edge);
  - lfsr advances as a Galois LFSR: lfsr <= (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0). It advances every enabled cycle, independent of mode and ftw.
- phase_clr=1: acc <= 0 and carry_r <= 0 regardless of en; takes priority over the accumulate. The lfsr is unaffected.
- Stage 2, on each edge with en=1:
  - out <= f(acc, lfsr, active cfg);
  - wrap <= carry_r.
  - Latency: out reflects the acc value one cycle old, so wrap aligns with the first sample after wrap-around.
- en=0: acc, lfsr and out hold; wrap <= 0.
- f() definitions, with p = acc[PHASE_W-1 -: OUT_W], h = p[OUT_W-1], u = p[OUT_W-2:0]:
  - mode 0, sine (parabolic): mag = (u*(N-1-u)) >> (OUT_W-3); out = h ? N-1-mag : N+mag. Product is unsigned, 2*(OUT_W-1) bits wide.
  - mode 1, square: out = (p < duty) ? MAX : 0. duty=0 gives constant 0.
  - mode 2, sawtooth: out = p.
  - mode 3, triangle: t = {u,1'b0}; out = h ? ~t : t.
  - mode 4, noise: out = lfsr[15 -: OUT_W].
  - mode 5, DC: out = duty.
  - modes 6 and 7: out = N.
- Reset mid-operation returns everything to reset values immediately; any pending config is discarded.

Test Plan:
- Reset with OUT_W=8, PHASE_W=16 -> out=128, wrap=0, cfg_ready=1. With en=1 and no config, out stays 128.
- Push mode=2, ftw=0x0100 with en=0, then en=1 -> out runs 0,1,…,255,0. wrap=1 exactly on each out=0 sample after the first, i.e. every 256 cycles.
- Mode 0, ftw=0x0100:
  - p=0x40 -> out=254; p=0x00 -> 128; p=0xC0 -> 1.
  - Output is symmetric about 128/127.
- Mode 1, duty=0x40, ftw=0x0100 -> repeating 64 cycles of 0xFF then 192 cycles of 0x00.
- Config handshake:
  - Running sawtooth mid-period, push mode=3 -> cfg_ready drops. A second cfg_valid is ignored while cfg_ready=0.
  - Sawtooth continues to 255; the triangle starts at out=0 with wrap=1; cfg_ready then rises.
  - phase_clr while pending -> applies immediately, acc=0.
- With en=0 from reset, push mode=4 and wait one edge, then en=1 -> out=0xAC, then 0xE2. Deasserting en holds out constant and forces wrap=0.

Source files
------------

// File: rtl/dds_func_gen.sv
// DDS function generator: phase accumulator plus waveform shaper with a
// shadowed configuration that only takes effect at period boundaries.
module dds_func_gen #(
    parameter int OUT_W   = 8,
    parameter int PHASE_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               phase_clr,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [2:0]         cfg_mode,
    input  logic [PHASE_W-1:0] cfg_ftw,
    input  logic [OUT_W-1:0]   cfg_duty,
    output logic [OUT_W-1:0]   out,
    output logic               wrap
);
    localparam int PW = 2 * (OUT_W - 1);
    localparam logic [OUT_W-1:0] MID    = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] MID_M1 = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] MAXV   = {OUT_W{1'b1}};

    logic [PHASE_W-1:0] acc_reg;
    logic               carry_reg;
    logic [15:0]        lfsr_reg;
    logic               pending_reg;
    logic [2:0]         sh_mode_reg, mode_reg;
    logic [PHASE_W-1:0] sh_ftw_reg, ftw_reg;
    logic [OUT_W-1:0]   sh_duty_reg, duty_reg;
    logic [OUT_W-1:0]   out_reg;
    logic               wrap_reg;

    logic [PHASE_W:0]   sum;
    logic               transfer;
    logic               apply;
    logic [OUT_W-1:0]   p;
    logic               h;
    logic [OUT_W-2:0]   u;
    logic [PW-1:0]      prod;
    logic [OUT_W-1:0]   mag;
    logic [OUT_W-1:0]   tri_t;
    logic [OUT_W-1:0]   wave_next;

    assign sum      = {1'b0, acc_reg} + {1'b0, ftw_reg};
    assign transfer = cfg_valid & ~pending_reg;
    // Apply only where a phase discontinuity is harmless: stopped, cleared, or at wrap.
    assign apply    = pending_reg & (~en | phase_clr | sum[PHASE_W]);

    assign cfg_ready = ~pending_reg;
    assign out       = out_reg;
    assign wrap      = wrap_reg;

    assign p     = acc_reg[PHASE_W-1 -: OUT_W];
    assign h     = p[OUT_W-1];
    assign u     = p[OUT_W-2:0];
    // N-1-u over OUT_W-1 bits is simply the bitwise complement of u.
    assign prod  = {{(OUT_W-1){1'b0}}, u} * {{(OUT_W-1){1'b0}}, ~u};
    assign mag   = OUT_W'(prod >> (OUT_W - 3));
    assign tri_t = {u, 1'b0};

    always_comb begin
        wave_next = MID;
        case (mode_reg)
            3'd0:    wave_next = h ? (MID_M1 - mag) : (MID + mag);
            3'd1:    wave_next = (p < duty_reg) ? MAXV : '0;
            3'd2:    wave_next = p;
            3'd3:    wave_next = h ? ~tri_t : tri_t;
            3'd4:    wave_next = lfsr_reg[15 -: OUT_W];
            3'd5:    wave_next = duty_reg;
            default: wave_next = MID;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg   <= '0;
            carry_reg <= 1'b0;
            lfsr_reg  <= 16'hACE1;
            out_reg   <= MID;
            wrap_reg  <= 1'b0;
        end else begin
            if (phase_clr) begin
                acc_reg   <= '0;
                carry_reg <= 1'b0;
            end else if (en) begin
                {carry_reg, acc_reg} <= sum;
            end
            if (en) begin
                lfsr_reg <= {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? 16'hB400 : 16'h0000);
                out_reg  <= wave_next;
                wrap_reg <= carry_reg;
            end else begin
                wrap_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_reg <= 1'b0;
            sh_mode_reg <= 3'd0;
            sh_ftw_reg  <= '0;
            sh_duty_reg <= MID;
            mode_reg    <= 3'd0;
            ftw_reg     <= '0;
            duty_reg    <= MID;
        end else if (transfer) begin
            sh_mode_reg <= cfg_mode;
            sh_ftw_reg  <= cfg_ftw;
            sh_duty_reg <= cfg_duty;
            pending_reg <= 1'b1;
        end else if (apply) begin
            mode_reg    <= sh_mode_reg;
            ftw_reg     <= sh_ftw_reg;
            duty_reg    <= sh_duty_reg;
            pending_reg <= 1'b0;
        end
    end
endmodule
